instruction_fetch: RTL and testbench

Fetch stage of the rv32I core. It owns the program counter, drives the word address into the combinational-read instruction memory, and captures each returned instruction with its PC into a 2-entry fetch buffer. The buffer feeds decode through a valid/ready handshake. Decode or execute can redirect the PC for branches and jumps, which also flushes every in-flight fetch.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_if.sv | 42 ++++
 rtl/fetch_buffer.sv | 81 ++++++++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch state machine encoding
//   fetch_entry_t : one fetch buffer entry {pc, instruction, misaligned}
//   NOP           : addi x0, x0, 0, used as the payload of trap markers
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET_ST = 2'd0,
    FETCH    = 2'd1,
    TRAP     = 2'd2,
    HALT     = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        misaligned;
  } fetch_entry_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle of the fetch stage.
//   imem_*      : word address out, combinational instruction read data in
//   redirect_*  : PC redirect request from decode/execute
//   out_*       : valid/ready stream of fetched entries towards decode
// master = fetch stage, slave = environment (memory, decode, redirect source).
interface instruction_fetch_if;

  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        out_misaligned;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instruction,
    output out_misaligned
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instruction,
    input  out_misaligned
  );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries with first-word fall-through head.
//   clk, reset  : clock, asynchronous active-high reset
//   push, entry : write entry at the tail (caller guarantees space)
//   pop         : drop the head entry (caller guarantees non-empty)
//   flush       : empty the FIFO; overrides push and pop
//   head        : oldest entry, read straight from storage
//   count       : number of entries held
//   full, empty : occupancy flags, decoded from the count flop
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = 2,
  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  fetch_entry_t        entry,
  output fetch_entry_t        head,
  output logic [CntW-1:0]     count,
  output logic                full,
  output logic                empty
);

  fetch_entry_t          mem_q [BUFFER_DEPTH];
  fetch_entry_t          mem_d [BUFFER_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      // Pointers are power-of-two wide, so they wrap for free.
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(BUFFER_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the rv32I core: PC register, fetch state machine, redirect
// handling and a fetch buffer feeding decode.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : instruction_fetch_if.master (imem, redirect, out stream)
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_fetch_if.master   bus
);

  localparam int unsigned CntW = $clog2(BUFFER_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [31:0]     pc_q, pc_d;

  logic            push, pop, pop_req, flush, can_push;
  fetch_entry_t    entry, head;
  logic [CntW-1:0] count;
  logic            full, empty;

  assign pop_req  = (count != '0) && bus.out_ready;
  // A full buffer still takes a push when the head leaves the same cycle.
  assign can_push = !full || pop_req;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = pop_req;
    flush   = 1'b0;
    entry   = '{pc: pc_q, instruction: bus.imem_instruction, misaligned: 1'b0};

    if (state_q != RESET_ST && bus.redirect_valid) begin
      // Redirect wins over push and pop; the pop this cycle is lost.
      flush   = 1'b1;
      pop     = 1'b0;
      pc_d    = bus.redirect_pc;
      state_d = (bus.redirect_pc[1:0] == 2'b00) ? FETCH : TRAP;
    end else begin
      unique case (state_q)
        RESET_ST: state_d = FETCH;
        FETCH: begin
          if (can_push) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        TRAP: begin
          // Memory data is meaningless at a misaligned PC; emit a marker.
          if (can_push) begin
            push    = 1'b1;
            entry   = '{pc: pc_q, instruction: NOP, misaligned: 1'b1};
            state_d = HALT;
          end
        end
        HALT: ;
        default: state_d = RESET_ST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_ST;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_fetch_buffer (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .entry (entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.imem_address    = pc_q;
  assign bus.out_valid       = !empty;
  assign bus.out_pc          = head.pc;
  assign bus.out_instruction = head.instruction;
  assign bus.out_misaligned  = head.misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC     (32'h0000_0000),
    .BUFFER_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: every word is its address xor a marker pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.imem_instruction = mem_word(bus.imem_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc,
                          input logic [31:0] ins, input logic mis);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_pc"}, bus.out_pc, pc);
    chk({tag, "_ins"}, bus.out_instruction, ins);
    chk({tag, "_mis"}, {31'd0, bus.out_misaligned}, {31'd0, mis});
  endtask

  // Reset for one edge, release, then step through E0 (-> FETCH).
  task automatic do_reset(input logic ready);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.out_ready = ready;
    tick();
    chk("e0_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    tick();
    tick();
    chk("rst_addr", bus.imem_address, 32'h0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_ins", bus.out_instruction, 32'h0);
    chk("rst_mis", {31'd0, bus.out_misaligned}, 32'd0);

    // Streaming with out_ready high: one entry per cycle, PCs +4.
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("e0_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("e0_addr", bus.imem_address, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_head("stream", 32'(4 * i), mem_word(32'(4 * i)), 1'b0);
    end

    // Backpressure: two entries held, pc frozen at 8.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk_head("hold", 32'h0, mem_word(32'h0), 1'b0);
    chk("hold_addr", bus.imem_address, 32'h8);
    bus.out_ready = 1'b1;
    tick();
    chk_head("drain1", 32'h4, mem_word(32'h4), 1'b0);
    tick();
    chk_head("drain2", 32'h8, mem_word(32'h8), 1'b0);

    // Redirect while full and popping: pop lost, one empty cycle.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rd20_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rd20_addr", bus.imem_address, 32'h20);
    tick();
    chk_head("rd20", 32'h20, mem_word(32'h20), 1'b0);

    // Misaligned redirect: single trap marker, then halt.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h22;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rd22_valid0", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk_head("trap", 32'h22, 32'h0000_0013, 1'b1);
    tick();
    chk("halt_valid1", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("halt_valid2", {31'd0, bus.out_valid}, 32'd0);
    chk("halt_addr", bus.imem_address, 32'h22);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rd40_addr", bus.imem_address, 32'h40);
    tick();
    chk_head("rd40", 32'h40, mem_word(32'h40), 1'b0);

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    chk_head("top", 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0);
    chk("wrap_addr", bus.imem_address, 32'h0);
    tick();
    chk_head("wrap", 32'h0, mem_word(32'h0), 1'b0);

    // Asynchronous reset mid-stream with two entries buffered.
    bus.out_ready = 1'b0;
    tick();
    chk_head("pre_rst", 32'h0, mem_word(32'h0), 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_addr", bus.imem_address, 32'h0);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("arst_e0_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk_head("restart0", 32'h0, mem_word(32'h0), 1'b0);
    tick();
    chk_head("restart1", 32'h4, mem_word(32'h4), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
